// File: rtl/wb_arb_pkg.sv
// Shared encodings and limits for the register-file write-back port arbiter.
// Imported by the round-robin core and the top level.
package wb_arb_pkg;

    typedef enum logic {
        LG_ALU = 1'b0,
        LG_MEM = 1'b1
    } lg_state_t;

    localparam logic       WB_SEL_ALU   = 1'b0;
    localparam logic       WB_SEL_MEM   = 1'b1;
    localparam logic [7:0] CONFLICT_MAX = 8'd255;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin grant with last-grant state.
// The state moves only when advance is high, i.e. when a grant turns into a transfer.
module rr_arb2
    import wb_arb_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic req_alu,
    input  logic req_mem,
    input  logic advance,
    output logic gnt_alu,
    output logic gnt_mem
);

    lg_state_t state_q;
    lg_state_t state_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= LG_MEM;
        end else begin
            state_q <= state_d;
        end
    end

    // On a tie the requester that did not win last time gets the port.
    always_comb begin
        gnt_alu = 1'b0;
        gnt_mem = 1'b0;
        state_d = state_q;
        if (req_alu && req_mem) begin
            if (state_q == LG_MEM) begin
                gnt_alu = 1'b1;
            end else begin
                gnt_mem = 1'b1;
            end
        end else begin
            gnt_alu = req_alu;
            gnt_mem = req_mem;
        end
        if (advance) begin
            state_d = gnt_mem ? LG_MEM : LG_ALU;
        end
    end

endmodule

// File: rtl/wb_port_arbiter.sv
// Shares the register-file write port between the ALU and load paths: round-robin
// grant, registered write strobe/address/data, stall hold and a conflict counter.
module wb_port_arbiter
    import wb_arb_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              alu_valid,
    output logic              alu_ready,
    input  logic [ADDR_W-1:0] alu_addr,
    input  logic [DATA_W-1:0] alu_data,
    input  logic              mem_valid,
    output logic              mem_ready,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_data,
    output logic              wb_sel,
    input  logic              wb_stall,
    output logic              wb_en,
    output logic [ADDR_W-1:0] wb_addr,
    output logic [DATA_W-1:0] wb_data,
    output logic [7:0]        conflict_cnt
);

    logic              hold_p0;
    logic              open_p0;
    logic              gnt_alu_p0;
    logic              gnt_mem_p0;
    logic              xfer_p0;
    logic              sel_q;
    logic              vld_p1;
    logic [ADDR_W-1:0] addr_p1;
    logic [DATA_W-1:0] data_p1;
    logic [7:0]        cnt_q;

    // Stage p0: arbitration. Requests are masked while reset is low or a write is held.
    assign hold_p0 = vld_p1 & wb_stall;
    assign open_p0 = rst_n & ~hold_p0;

    rr_arb2 u_rr (
        .clk     (clk),
        .rst_n   (rst_n),
        .req_alu (alu_valid & open_p0),
        .req_mem (mem_valid & open_p0),
        .advance (xfer_p0),
        .gnt_alu (gnt_alu_p0),
        .gnt_mem (gnt_mem_p0)
    );

    assign xfer_p0   = gnt_alu_p0 | gnt_mem_p0;
    assign alu_ready = gnt_alu_p0;
    assign mem_ready = gnt_mem_p0;
    assign wb_sel    = xfer_p0 ? (gnt_mem_p0 ? WB_SEL_MEM : WB_SEL_ALU) : sel_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_q <= WB_SEL_ALU;
        end else begin
            sel_q <= wb_sel;
        end
    end

    // Stage p1: registered write to the register file, frozen while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1  <= 1'b0;
            addr_p1 <= '0;
            data_p1 <= '0;
        end else if (!hold_p0) begin
            vld_p1 <= xfer_p0;
            if (xfer_p0) begin
                addr_p1 <= gnt_mem_p0 ? mem_addr : alu_addr;
                data_p1 <= gnt_mem_p0 ? mem_data : alu_data;
            end
        end
    end

    assign wb_en   = vld_p1;
    assign wb_addr = addr_p1;
    assign wb_data = data_p1;

    // Contention counts regardless of hold, and sticks at its maximum.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (alu_valid && mem_valid && (cnt_q != CONFLICT_MAX)) begin
            cnt_q <= cnt_q + 8'd1;
        end
    end

    assign conflict_cnt = cnt_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Bench for wb_port_arbiter: directed literal checks plus randomized traffic
// compared every cycle against a behavioural model of the arbitration rules.
module tb_wb_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        alu_valid, mem_valid, wb_stall;
    logic [2:0]  alu_addr, mem_addr;
    logic [15:0] alu_data, mem_data;
    logic        alu_ready, mem_ready, wb_sel, wb_en;
    logic [2:0]  wb_addr;
    logic [15:0] wb_data;
    logic [7:0]  conflict_cnt;

    wb_port_arbiter #(.DATA_W(16), .ADDR_W(3)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .alu_valid    (alu_valid),
        .alu_ready    (alu_ready),
        .alu_addr     (alu_addr),
        .alu_data     (alu_data),
        .mem_valid    (mem_valid),
        .mem_ready    (mem_ready),
        .mem_addr     (mem_addr),
        .mem_data     (mem_data),
        .wb_sel       (wb_sel),
        .wb_stall     (wb_stall),
        .wb_en        (wb_en),
        .wb_addr      (wb_addr),
        .wb_data      (wb_data),
        .conflict_cnt (conflict_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Model state: last winner (1 = MEM), registered write, held select, counter.
    logic        m_last;
    logic        m_en;
    logic [2:0]  m_addr;
    logic [15:0] m_data;
    logic        m_sel;
    int          m_cnt;
    logic        e_ar, e_mr, e_sel;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic model_reset();
        m_last = 1'b1;
        m_en   = 1'b0;
        m_addr = '0;
        m_data = '0;
        m_sel  = 1'b0;
        m_cnt  = 0;
    endtask

    task automatic model_comb();
        logic hold;
        e_ar = 1'b0;
        e_mr = 1'b0;
        if (!rst_n) begin
            e_sel = 1'b0;
        end else begin
            hold = m_en && wb_stall;
            if (!hold) begin
                if (alu_valid && mem_valid) begin
                    if (m_last) e_ar = 1'b1;
                    else        e_mr = 1'b1;
                end else begin
                    e_ar = alu_valid;
                    e_mr = mem_valid;
                end
            end
            e_sel = e_mr ? 1'b1 : (e_ar ? 1'b0 : m_sel);
        end
    endtask

    task automatic model_edge();
        if (!rst_n) begin
            model_reset();
        end else begin
            if (alu_valid && mem_valid && m_cnt < 255) m_cnt++;
            if (e_ar || e_mr) begin
                m_en   = 1'b1;
                m_addr = e_mr ? mem_addr : alu_addr;
                m_data = e_mr ? mem_data : alu_data;
                m_last = e_mr;
            end else if (!(m_en && wb_stall)) begin
                m_en = 1'b0;
            end
            m_sel = e_sel;
        end
    endtask

    task automatic compare_all();
        chk("alu_ready",    32'(alu_ready),    32'(e_ar));
        chk("mem_ready",    32'(mem_ready),    32'(e_mr));
        chk("wb_sel",       32'(wb_sel),       32'(e_sel));
        chk("wb_en",        32'(wb_en),        32'(m_en));
        chk("wb_addr",      32'(wb_addr),      32'(m_addr));
        chk("wb_data",      32'(wb_data),      32'(m_data));
        chk("conflict_cnt", 32'(conflict_cnt), m_cnt);
    endtask

    // Called just after a negedge with inputs already driven; returns at the next negedge.
    task automatic step();
        #1;
        model_comb();
        compare_all();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    logic        a_pend, m_pend;
    logic [2:0]  a_addr_r, m_addr_r;
    logic [15:0] a_dat_r, m_dat_r;
    logic [1:0]  exp_rdy [4];
    logic [15:0] exp_dat [4];

    initial begin
        model_reset();
        rst_n     = 1'b0;
        alu_valid = 1'b1; alu_addr = 3'd1; alu_data = 16'h0011;
        mem_valid = 1'b1; mem_addr = 3'd2; mem_data = 16'h0022;
        wb_stall  = 1'b0;
        @(negedge clk);

        // Reset with both requesters pending.
        #1;
        chk("rst_alu_ready", 32'(alu_ready), 32'd0);
        chk("rst_mem_ready", 32'(mem_ready), 32'd0);
        chk("rst_wb_en",     32'(wb_en),     32'd0);
        chk("rst_wb_addr",   32'(wb_addr),   32'd0);
        chk("rst_wb_data",   32'(wb_data),   32'd0);
        chk("rst_cnt",       32'(conflict_cnt), 32'd0);
        step();
        step();

        // Contention: strict alternation starting with ALU.
        rst_n = 1'b1;
        exp_rdy = '{2'b10, 2'b01, 2'b10, 2'b01};
        exp_dat = '{16'h0011, 16'h0022, 16'h0011, 16'h0022};
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("cont_grant", 32'({alu_ready, mem_ready}), 32'(exp_rdy[i]));
            step();
            chk("cont_wb_data", 32'(wb_data), 32'(exp_dat[i]));
        end
        chk("cont_cnt", 32'(conflict_cnt), 32'd4);
        alu_valid = 1'b0;
        mem_valid = 1'b0;
        step();

        // Single requester.
        alu_valid = 1'b1; alu_addr = 3'd3; alu_data = 16'hA5A5;
        #1;
        chk("single_ready", 32'(alu_ready), 32'd1);
        chk("single_sel",   32'(wb_sel),    32'd0);
        step();
        chk("single_en",   32'(wb_en),   32'd1);
        chk("single_addr", 32'(wb_addr), 32'd3);
        chk("single_data", 32'(wb_data), 32'hA5A5);

        // Stall with a pending load.
        alu_valid = 1'b0;
        mem_valid = 1'b1; mem_addr = 3'd5; mem_data = 16'hBEEF;
        wb_stall  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("stall_mem_ready", 32'(mem_ready), 32'd0);
            step();
            chk("stall_en",   32'(wb_en),   32'd1);
            chk("stall_data", 32'(wb_data), 32'hA5A5);
        end
        wb_stall = 1'b0;
        #1;
        chk("unstall_mem_ready", 32'(mem_ready), 32'd1);
        step();
        chk("unstall_data", 32'(wb_data), 32'hBEEF);
        mem_valid = 1'b0;
        step();

        // Randomized traffic with requesters obeying the hold-until-ready rule.
        a_pend = 1'b0; m_pend = 1'b0;
        a_addr_r = '0; m_addr_r = '0; a_dat_r = '0; m_dat_r = '0;
        for (int i = 0; i < 400; i++) begin
            if (!a_pend && $urandom_range(0, 2) != 0) begin
                a_pend = 1'b1; a_addr_r = 3'($urandom); a_dat_r = 16'($urandom);
            end
            if (!m_pend && $urandom_range(0, 2) != 0) begin
                m_pend = 1'b1; m_addr_r = 3'($urandom); m_dat_r = 16'($urandom);
            end
            alu_valid = a_pend; alu_addr = a_addr_r; alu_data = a_dat_r;
            mem_valid = m_pend; mem_addr = m_addr_r; mem_data = m_dat_r;
            wb_stall  = ($urandom_range(0, 3) == 0);
            step();
            if (e_ar) a_pend = 1'b0;
            if (e_mr) m_pend = 1'b0;
        end

        // Saturation of the conflict counter.
        wb_stall  = 1'b0;
        alu_valid = 1'b1; alu_addr = 3'd1; alu_data = 16'h0011;
        mem_valid = 1'b1; mem_addr = 3'd2; mem_data = 16'h0022;
        for (int i = 0; i < 300; i++) step();
        chk("sat_cnt", 32'(conflict_cnt), 32'd255);

        // Reset during a held write.
        mem_valid = 1'b0;
        step();
        alu_valid = 1'b0;
        wb_stall  = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_wb_en", 32'(wb_en),        32'd0);
        chk("midrst_cnt",   32'(conflict_cnt), 32'd0);
        model_reset();
        step();
        rst_n     = 1'b1;
        wb_stall  = 1'b0;
        alu_valid = 1'b1;
        mem_valid = 1'b1;
        #1;
        chk("midrst_tie", 32'({alu_ready, mem_ready}), 32'b10);
        step();
        step();
        alu_valid = 1'b0;
        mem_valid = 1'b0;
        step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/wb_port_arbiter.md
# wb_port_arbiter

Sequential arbiter that shares the single 16-bit register-file write port between two write-back sources: the ALU result path and the memory load path. Each cycle it picks one requester using two-way round-robin, drives the select of the write-back 2:1 data mux, and presents a registered write strobe, address and data to the register file. Valid/ready handshakes on each requester side give back-pressure, and a stall input from the register file holds the output stage.

## Interface
Parameters:
- DATA_W, 16, write-back data width
- ADDR_W, 3, register address width (8 registers)

Ports:
- clk  input  1  single clock; all state updates on rising edge
- rst_n  input  1  asynchronous, active-low reset
- alu_valid  input  1  ALU requester has a result to write
- alu_ready  output  1  ALU result accepted this cycle
- alu_addr  input  ADDR_W  ALU destination register
- alu_data  input  DATA_W  ALU result
- mem_valid  input  1  load requester has data to write
- mem_ready  output  1  load data accepted this cycle
- mem_addr  input  ADDR_W  load destination register
- mem_data  input  DATA_W  load data
- wb_sel  output  1  write-back mux select; 0 = ALU, 1 = MEM; combinational, equals current grant
- wb_stall  input  1  register file cannot accept a write this cycle
- wb_en  output  1  registered write strobe
- wb_addr  output  ADDR_W  registered write address
- wb_data  output  DATA_W  registered write data
- conflict_cnt  output  8  saturating count of cycles where both requesters were valid

## Operation
- Holding condition: hold = wb_en & wb_stall. While hold is 1, alu_ready = mem_ready = 0, and wb_en, wb_addr and wb_data keep their values.
- Grant when hold = 0:
  - Only alu_valid is set: grant ALU.
  - Only mem_valid is set: grant MEM.
  - Both are set: grant the requester not in last_grant.
  - Neither is set: grant none, and wb_sel keeps its previous value.
- alu_ready = grant_alu & ~hold. mem_ready = grant_mem & ~hold. Both are combinational and never high together.
- A transfer is valid & ready at a clock edge. On a transfer:
  - wb_en is set to 1.
  - wb_addr and wb_data load the granted requester's addr/data.
  - last_grant updates to the granted requester.
- With hold = 0 and no transfer, wb_en goes to 0. wb_addr and wb_data keep their values.
- FSM, state = last_grant with encodings LG_ALU and LG_MEM. Reset state is LG_MEM, so the ALU wins the first tie. The state changes only on a transfer.
- conflict_cnt increments on every cycle with alu_valid & mem_valid, including hold cycles. It saturates at 255 and does not wrap.
- Requesters must keep valid, addr and data stable until ready. The arbiter does not check this.
- Equal destination addresses on both sides get no special treatment. The writes are serialized in grant order.

## Timing
- Reset values (asserted asynchronously):
  - wb_en = 0, wb_addr = 0, wb_data = 0
  - wb_sel = 0
  - last_grant = LG_MEM
  - conflict_cnt = 0
  - alu_ready = mem_ready = 0 while rst_n is low
- Latency: a transfer at edge N makes wb_en, wb_addr and wb_data visible after edge N, and the register file samples them at edge N+1.
- Throughput is one write per cycle when wb_stall = 0.
  - Both requesters continuously valid: strict alternation ALU, MEM, ALU, ...
- wb_stall is sampled combinationally. It only matters while wb_en = 1.
  - When wb_stall falls, the held write completes at that edge, and a new transfer may happen in the same cycle (back-to-back).
- Reset deasserted mid-stream: the first cycle after release behaves as from the reset state. Any in-flight held write is lost, by design.
- Simultaneous events: a new valid arriving in a hold cycle is not granted until the hold clears. The round-robin decision uses last_grant at that later cycle.

## Structure
- Shared package (wb_arb_pkg) holds:
  - LG_ALU / LG_MEM state encodings
  - WB_SEL_ALU = 0, WB_SEL_MEM = 1
  - CONFLICT_MAX = 8'd255
- One sub-module, rr_arb2: a two-input round-robin grant function with last_grant state and an advance enable. The top level adds the output register, the hold logic, the counter and the wb_sel hold register.
- The data mux stays external. This block only drives its select.

## Test plan
- Reset: hold rst_n = 0 with both valids high -> both readys 0, wb_en = 0, wb_addr = 0, wb_data = 0, conflict_cnt = 0.
- Single requester: alu_valid with addr = 3, data = 16'hA5A5 -> alu_ready = 1 and wb_sel = 0 in the same cycle; next cycle wb_en = 1, wb_addr = 3, wb_data = 16'hA5A5.
- Contention: both valid for 4 cycles (ALU addr 1 / data 16'h0011, MEM addr 2 / data 16'h0022) ->
  - grant order ALU, MEM, ALU, MEM
  - wb_data sequence 0011, 0022, 0011, 0022
  - conflict_cnt = 4
- Stall: wb_stall = 1 for 3 cycles while wb_en = 1, mem_valid pending -> outputs frozen and mem_ready = 0 for 3 cycles; mem is granted in the cycle wb_stall falls.
- Saturation: both valid for 300 cycles -> conflict_cnt stops at 255.
- Reset mid-stream: assert rst_n during a held write -> wb_en drops immediately (asynchronously); after release the first tie goes to the ALU.
